// File: rtl/ibexsis_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   RAM_BASE_C / RAM_SIZE_C : default byte address window of the on-chip data RAM
//   req_id_e                : requester index (CPU data port or auxiliary master)
//   inflight_t              : one-deep outstanding-access tracking record
package ibexsis_pkg;

    localparam logic [31:0] RAM_BASE_C = 32'h0000_3000;
    localparam logic [31:0] RAM_SIZE_C = 32'h0000_1000;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AUX = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
        logic    err;
    } inflight_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Data-memory bus between one requester and the arbiter.
//   req/we/be/addr/wdata : request fields, driven by the requester
//   gnt                  : same-cycle grant
//   rvalid/rdata/err     : response, one cycle after the grant
// Modports: master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 4
);
    logic          req;
    logic          we;
    logic [SW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ram_arb_prio.sv
// Winner selection between requester 0 (CPU) and requester 1 (aux master).
// Grants are combinational from the requests; only the fairness state is
// registered.
// Build option RAM_ARB_RR_EN:
//   undefined : requester 0 has fixed priority; starve_cnt forces requester 1
//               to win after STARVE_LIMIT consecutive denied cycles.
//   defined   : 1-bit round-robin; ties go to the requester that did not win last.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req0, req1 : requests
//   gnt0, gnt1 : one-hot (or zero) grants
module ram_arb_prio
    import ibexsis_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef RAM_ARB_RR_EN

    // Reset to AUX so the CPU takes the first tie.
    req_id_e last_winner;

    always_comb begin
        gnt1 = req1 & (~req0 | (last_winner == REQ_CPU));
        gnt0 = req0 & ~gnt1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= REQ_AUX;
        end else if (gnt0) begin
            last_winner <= REQ_CPU;
        end else if (gnt1) begin
            last_winner <= REQ_AUX;
        end
    end

`else

    localparam int             CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;
    logic          force_aux;

    always_comb begin
        force_aux      = (starve_cnt == LIMIT);
        gnt1           = req1 & (~req0 | force_aux);
        gnt0           = req0 & ~gnt1;
        starve_cnt_nxt = starve_cnt;
        if (!req1 || gnt1) begin
            starve_cnt_nxt = '0;
        end else if (!force_aux) begin
            starve_cnt_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between the CPU data port (m0) and an
// auxiliary master (m1). The winner's request is muxed onto ram_* in the grant
// cycle; the response (grant + 1) is steered back using a one-deep in-flight
// register, so back-to-back grants run at full throughput. Accesses outside
// the RAM window are granted but never reach the RAM; the owner gets
// rvalid + err with zero read data.
// Build option RAM_ARB_RR_EN selects round-robin arbitration (see ram_arb_prio).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   m0, m1              : requester buses (slave modport)
//   ram_req/we/be/addr/wdata : RAM request, ram_addr is a word address
//   ram_rvalid, ram_rdata    : RAM response (rvalid is not used for steering)
module ram_port_arbiter
    import ibexsis_pkg::*;
#(
    parameter int          DW           = 32,
    parameter int          AW           = 32,
    parameter int          SW           = 4,
    parameter logic [31:0] RAM_BASE     = RAM_BASE_C,
    parameter logic [31:0] RAM_SIZE     = RAM_SIZE_C,
    parameter int          RAM_AW       = 10,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave m0,
    ram_port_arbiter_if.slave m1,
    output logic              ram_req,
    output logic              ram_we,
    output logic [SW-1:0]     ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic              ram_rvalid,
    input  logic [DW-1:0]     ram_rdata
);

    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    req_id_e       win_id;
    logic          sel_we;
    logic [SW-1:0] sel_be;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [AW-1:0] offset;
    logic          in_range;
    inflight_t     fl;

    ram_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk  (clk),
        .rst  (rst),
        .req0 (m0.req),
        .req1 (m1.req),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign m0.gnt  = gnt0;
    assign m1.gnt  = gnt1;
    assign any_gnt = gnt0 | gnt1;
    assign win_id  = gnt1 ? REQ_AUX : REQ_CPU;

    always_comb begin
        sel_we    = m0.we;
        sel_be    = m0.be;
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        if (gnt1) begin
            sel_we    = m1.we;
            sel_be    = m1.be;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end
    end

    // Addresses below the base wrap to large offsets, so one unsigned compare
    // covers both ends of the window.
    assign offset   = sel_addr - AW'(RAM_BASE);
    assign in_range = (offset < AW'(RAM_SIZE));

    assign ram_req   = any_gnt & in_range;
    assign ram_we    = ram_req & sel_we;
    assign ram_be    = sel_be;
    assign ram_addr  = offset[RAM_AW+1:2];
    assign ram_wdata = sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            fl <= '0;
        end else if (any_gnt) begin
            fl.valid <= 1'b1;
            fl.id    <= win_id;
            fl.err   <= ~in_range;
        end else begin
            fl <= '0;
        end
    end

    assign m0.rvalid = fl.valid & (fl.id == REQ_CPU);
    assign m1.rvalid = fl.valid & (fl.id == REQ_AUX);
    assign m0.err    = m0.rvalid & fl.err;
    assign m1.err    = m1.rvalid & fl.err;
    assign m0.rdata  = (m0.rvalid & ~fl.err) ? ram_rdata : '0;
    assign m1.rdata  = (m1.rvalid & ~fl.err) ? ram_rdata : '0;

    // Response timing is fixed at grant + 1, so ram_rvalid carries no extra
    // information; the bits of offset above the window are likewise unused.
    logic unused_bits;
    assign unused_bits = ^{ram_rvalid, offset[AW-1:RAM_AW+2], offset[1:0]};

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
    import ibexsis_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int RAM_AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              ram_req;
    logic              ram_we;
    logic [SW-1:0]     ram_be;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic              ram_rvalid;
    logic [DW-1:0]     ram_rdata;

    logic [DW-1:0]     mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    ram_port_arbiter_if #(.DW(DW), .AW(AW), .SW(SW)) m0_bus ();
    ram_port_arbiter_if #(.DW(DW), .AW(AW), .SW(SW)) m1_bus ();

    ram_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_bus.slave),
        .m1         (m1_bus.slave),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_be     (ram_be),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, byte-enabled writes; rdata holds its
    // last value when idle so zero-data on err responses is really tested.
    always @(posedge clk) begin
        ram_rvalid <= ram_req;
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [SW-1:0] be,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m0_bus.req = req; m0_bus.we = we; m0_bus.be = be;
        m0_bus.addr = addr; m0_bus.wdata = wdata;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [SW-1:0] be,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m1_bus.req = req; m1_bus.we = we; m1_bus.be = be;
        m1_bus.addr = addr; m1_bus.wdata = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_g1;
        logic prev_g1;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'h1234_5678;
        ram_rvalid = 1'b0;
        ram_rdata  = 32'hA5A5_A5A5;
        rst = 1'b1;
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_gnt",    32'(m0_bus.gnt),    0);
        check("rst_m1_gnt",    32'(m1_bus.gnt),    0);
        check("rst_m0_rvalid", 32'(m0_bus.rvalid), 0);
        check("rst_m1_rvalid", 32'(m1_bus.rvalid), 0);
        check("rst_m0_err",    32'(m0_bus.err),    0);
        check("rst_ram_req",   32'(ram_req),       0);
        check("rst_m0_rdata",  m0_bus.rdata,       0);
        step();
        rst = 1'b0;

        // Single read by m0 at 0x3010 -> word 4.
        drv0(1, 0, 4'hF, 32'h3010, 32'h0);
        @(negedge clk);
        check("rd_m0_gnt",   32'(m0_bus.gnt), 1);
        check("rd_m1_gnt",   32'(m1_bus.gnt), 0);
        check("rd_ram_req",  32'(ram_req),    1);
        check("rd_ram_we",   32'(ram_we),     0);
        check("rd_ram_addr", 32'(ram_addr),   4);
        step();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("rd_m0_rvalid", 32'(m0_bus.rvalid), 1);
        check("rd_m0_rdata",  m0_bus.rdata,       32'h1234_5678);
        check("rd_m0_err",    32'(m0_bus.err),    0);
        check("rd_m1_rvalid", 32'(m1_bus.rvalid), 0);

        // m0 writes, m1 reads the same word on the next cycle.
        step();
        drv0(1, 1, 4'hF, 32'h3000, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_m0_gnt",    32'(m0_bus.gnt), 1);
        check("wr_ram_we",    32'(ram_we),     1);
        check("wr_ram_addr",  32'(ram_addr),   0);
        check("wr_ram_wdata", ram_wdata,       32'hDEAD_BEEF);
        step();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        drv1(1, 0, 4'hF, 32'h3000, 32'h0);
        @(negedge clk);
        check("b2b_m1_gnt",    32'(m1_bus.gnt),    1);
        check("b2b_m0_rvalid", 32'(m0_bus.rvalid), 1);
        check("b2b_m1_rvalid", 32'(m1_bus.rvalid), 0);
        step();
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("b2b_m1_rvalid2", 32'(m1_bus.rvalid), 1);
        check("b2b_m1_rdata",   m1_bus.rdata,       32'hDEAD_BEEF);
        check("b2b_m0_rvalid2", 32'(m0_bus.rvalid), 0);

        // Out of range above the window.
        step();
        drv1(1, 0, 4'hF, 32'h4004, 32'h0);
        @(negedge clk);
        check("oor_m1_gnt",  32'(m1_bus.gnt), 1);
        check("oor_ram_req", 32'(ram_req),    0);
        step();
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("oor_m1_rvalid", 32'(m1_bus.rvalid), 1);
        check("oor_m1_err",    32'(m1_bus.err),    1);
        check("oor_m1_rdata",  m1_bus.rdata,       0);
        check("oor_m0_rvalid", 32'(m0_bus.rvalid), 0);

        // Just below the window (write must be dropped), then last in-range word.
        step();
        drv0(1, 1, 4'hF, 32'h2FFC, 32'h1111_1111);
        @(negedge clk);
        check("low_ram_req", 32'(ram_req), 0);
        step();
        drv0(1, 0, 4'hF, 32'h3FFC, 32'h0);
        @(negedge clk);
        check("low_m0_err",   32'(m0_bus.err), 1);
        check("top_ram_req",  32'(ram_req),    1);
        check("top_ram_addr", 32'(ram_addr),   32'h3FF);
        step();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("top_m0_err",   32'(m0_bus.err), 0);
        check("top_m0_rdata", m0_bus.rdata,    0);

        // Both requesting continuously from a fresh reset.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv0(1, 0, 4'hF, 32'h3020, 32'h0);
        drv1(1, 0, 4'hF, 32'h3024, 32'h0);
        prev_g1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
`ifdef RAM_ARB_RR_EN
            exp_g1 = (i % 2) == 1;
`else
            exp_g1 = (i % 5) == 4;
`endif
            check($sformatf("arb_m1_gnt_%0d", i), 32'(m1_bus.gnt), 32'(exp_g1));
            check($sformatf("arb_m0_gnt_%0d", i), 32'(m0_bus.gnt), 32'(!exp_g1));
            if (i > 0) begin
                check($sformatf("arb_m1_rvalid_%0d", i), 32'(m1_bus.rvalid), 32'(prev_g1));
                check($sformatf("arb_m0_rvalid_%0d", i), 32'(m0_bus.rvalid), 32'(!prev_g1));
            end
            prev_g1 = exp_g1;
            step();
        end

        // Reset while responses are pending and m1 is being starved.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("mid_m0_rvalid", 32'(m0_bus.rvalid), 0);
        check("mid_m1_rvalid", 32'(m1_bus.rvalid), 0);
`ifndef RAM_ARB_RR_EN
        check("mid_starve_cnt", 32'(dut.u_prio.starve_cnt), 0);
`endif
        step();
        @(negedge clk);
        check("mid_m0_rvalid2", 32'(m0_bus.rvalid), 0);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
